rv32v_uop_sequencer: RTL and testbench
======================================

# rv32v_uop_sequencer

Two-lane element sequencer for the RV32V vector unit. It accepts one decoded vector instruction's length configuration and emits one micro-op per cycle toward execute. Each micro-op covers two element slots (lane 0 and lane 1) with element offsets, destination register, in-register element index and per-lane write enables. It sits between vector decode and the decode/execute pipeline register, supplies the per-lane offset/wen/vd fields of that interface, and honours execute backpressure and pipeline flush.

## Interface
Parameters:
- VLEN, 128: vector register width in bits; fixes elements per register (EPR) = VLEN/SEW.
- OFF_W, 7: element offset width; covers VLMAX = 128 (e8, m8).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- start_valid  in  1  decode presents a new instruction.
- start_ready  out  1  sequencer can accept a new instruction.
- vl  in  32  requested vector length.
- vstart  in  OFF_W  first element to process.
- sew  in  sew_t  element width: SEW8, SEW16 or SEW32.
- lmul  in  vlmul_t  register-group multiplier: m1/m2/m4/m8 or mf2/mf4/mf8.
- vd  in  5  base destination register.
- stall  in  1  execute cannot take a micro-op this cycle.
- flush  in  1  abandon the current instruction.
- uop_valid  out  1  micro-op fields are valid.
- woffset0, woffset1  out  offset_t  element index for lane 0 and lane 1.
- vd0, vd1  out  5  physical register holding each lane's element.
- elem0, elem1  out  4  element index inside that register.
- wen0, wen1  out  1  lane holds a live element.
- uop_last  out  1  final micro-op of the instruction.
- done  out  1  one-cycle completion pulse.
- busy  out  1  state is not IDLE.

## Operation
- FSM states: IDLE and RUN. start_ready = (state == IDLE) and not RST.
- Accepting an instruction (start_valid && start_ready):
  - Latch sew, lmul and vd.
  - Compute vlmax = EPR << lmul for integer LMUL, or EPR >> n for mfN.
  - eff_vl = min(vl, vlmax). vl is compared at its full 32-bit width before truncation.
- If vstart >= eff_vl (this includes vl = 0): no micro-ops are issued. done pulses on the next cycle and the FSM stays in IDLE.
- Otherwise: idx <= vstart and the FSM moves to RUN.
- In RUN, all outputs are driven from registers:
  - uop_valid = 1.
  - woffset0 = idx, woffset1 = idx + 1.
  - wen0 = 1; wen1 = (idx + 1 < eff_vl).
  - vdK = vd + (woffsetK >> log2(EPR)); elemK = woffsetK & (EPR − 1).
  - uop_last = (idx + 2 >= eff_vl).
- Advance: when stall = 0, idx <= idx + 2. If uop_last, go to IDLE and pulse done in the same cycle as the last micro-op's acceptance edge (done is high the cycle after).
- stall = 1 holds every output unchanged.
- flush (any state) forces IDLE on the next edge. done is not asserted. flush has priority over stall and over start acceptance.
- Odd vstart is legal: lane 0 begins at the odd element, and the last micro-op may have wen1 = 0.
- When wen1 = 0, woffset1 is still idx + 1. Consumers gate on wen1.
- Reset: state IDLE, idx 0. All outputs are 0 except start_ready, which is 1 after reset deasserts.

## Timing
- Acceptance to first uop_valid: 1 cycle.
- Throughput: 1 micro-op per cycle with no stall. An instruction takes ceil((eff_vl − vstart)/2) cycles of RUN plus the stall cycles.
- start_ready returns high the cycle after the last micro-op is accepted. Back-to-back instructions therefore leave one IDLE cycle between them.
- done is high for exactly 1 cycle, in the IDLE cycle after the last accepted micro-op.
- Simultaneous flush and last-accept: the flush wins and done stays low.
- RST asserted mid-RUN: outputs are zero on the next edge.

## Structure
- Shared types belong in rv32v_types_pkg: sew_t, vlmul_t, offset_t (OFF_W bits) and the VLEN constant.
- One combinational sub-module, rv32v_vlmax_calc: takes (sew, lmul, vl) and returns (vlmax, eff_vl, epr_log2). Both the acceptance path and a future vsetvl unit reuse it.
- The FSM, idx counter and output registers live in the top module.

## Test plan
- e32 m1, vl = 4, vstart = 0, vd = 8, no stall -> two micro-ops (0/1 on v8 elem 0/1, then 2/3 on v8 elem 2/3). The second micro-op has uop_last = 1. done pulses once, 1 cycle later.
- e8 m2, vl = 20, vstart = 15 -> micro-ops (15,16), (17,18), (19,x). Element 16 maps to v(vd+1) elem 0. The final micro-op has wen1 = 0.
- e32 mf2, vl = 9 -> vlmax = 2, eff_vl = 2, one micro-op. Also vl = 0 -> no uop_valid, done pulses 1 cycle after acceptance.
- e16 m1, vl = 8, stall held 3 cycles on the 2nd micro-op -> its fields are stable for all 4 cycles, then the sequence resumes. Total 4 micro-ops.
- flush on the 2nd micro-op of a 4-micro-op instruction -> uop_valid = 0 next cycle, no done, start_ready = 1. A new start is accepted cleanly.
- RST pulsed mid-RUN -> all outputs are 0 on the next edge and the FSM is in IDLE.

Source files
------------

// File: rtl/rv32v_types_pkg.sv
// Shared element-width, register-group and offset types for the RV32V
// vector issue path.
package rv32v_types_pkg;

  localparam int unsigned VLEN  = 128;
  localparam int unsigned OFF_W = 7;

  typedef enum logic [1:0] {
    SEW8  = 2'd0,
    SEW16 = 2'd1,
    SEW32 = 2'd2
  } sew_t;

  // Encoding follows vtype.vlmul; 3'b100 is reserved.
  typedef enum logic [2:0] {
    LMUL_1  = 3'd0,
    LMUL_2  = 3'd1,
    LMUL_4  = 3'd2,
    LMUL_8  = 3'd3,
    LMUL_F8 = 3'd5,
    LMUL_F4 = 3'd6,
    LMUL_F2 = 3'd7
  } vlmul_t;

  typedef logic [OFF_W-1:0] offset_t;

endpackage

// File: rtl/rv32v_vlmax_calc.sv
// Combinational VLMAX / effective-VL calculator, shared by instruction
// acceptance and vsetvl.
module rv32v_vlmax_calc
  import rv32v_types_pkg::*;
#(
  parameter int unsigned VLEN_P  = VLEN,
  parameter int unsigned OFF_W_P = OFF_W,
  parameter int unsigned LOG_W   = $clog2($clog2(VLEN_P / 8) + 1)
) (
  input  sew_t               sew,
  input  vlmul_t             lmul,
  input  logic [31:0]        vl,
  output logic [OFF_W_P:0]   vlmax,
  output logic [OFF_W_P:0]   eff_vl,
  output logic [LOG_W-1:0]   epr_log2
);

  localparam int unsigned MAX_L2 = $clog2(VLEN_P / 8);

  logic [OFF_W_P:0] epr;

  always_comb begin
    epr_log2 = LOG_W'(MAX_L2 - 32'(sew));
    epr      = {{OFF_W_P{1'b0}}, 1'b1} << epr_log2;
    // Fractional LMUL divides; too small a fraction rounds vlmax to zero.
    if (lmul[2]) vlmax = epr >> (3'd4 - {1'b0, lmul[1:0]});
    else         vlmax = epr << lmul[1:0];
    eff_vl = (vl < 32'(vlmax)) ? vl[OFF_W_P:0] : vlmax;
  end

endmodule

// File: rtl/rv32v_uop_sequencer.sv
// Two-lane element sequencer: turns one vector instruction's length
// configuration into a stream of registered two-element micro-ops.
module rv32v_uop_sequencer
  import rv32v_types_pkg::*;
#(
  parameter int unsigned VLEN_P  = VLEN,
  parameter int unsigned OFF_W_P = OFF_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [31:0]        vl,
  input  logic [OFF_W_P-1:0] vstart,
  input  sew_t               sew,
  input  vlmul_t             lmul,
  input  logic [4:0]         vd,
  input  logic               stall,
  input  logic               flush,
  output logic               uop_valid,
  output logic [OFF_W_P-1:0] woffset0,
  output logic [OFF_W_P-1:0] woffset1,
  output logic [4:0]         vd0,
  output logic [4:0]         vd1,
  output logic [3:0]         elem0,
  output logic [3:0]         elem1,
  output logic               wen0,
  output logic               wen1,
  output logic               uop_last,
  output logic               done,
  output logic               busy
);

  localparam int unsigned LOG_W = $clog2($clog2(VLEN_P / 8) + 1);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic               valid;
    logic [OFF_W_P-1:0] woffset0;
    logic [OFF_W_P-1:0] woffset1;
    logic [4:0]         vd0;
    logic [4:0]         vd1;
    logic [3:0]         elem0;
    logic [3:0]         elem1;
    logic               wen0;
    logic               wen1;
    logic               last;
  } uop_t;

  state_t             state_q, state_d;
  logic [OFF_W_P:0]   idx_q, idx_d;
  logic [OFF_W_P:0]   evl_q, evl_d;
  logic [LOG_W-1:0]   l2_q, l2_d;
  logic [4:0]         vd_q, vd_d;
  uop_t               uop_q, uop_d;
  logic               done_q, done_d;

  logic [OFF_W_P:0]   calc_vlmax;
  logic [OFF_W_P:0]   calc_evl;
  logic [LOG_W-1:0]   calc_l2;

  rv32v_vlmax_calc #(
    .VLEN_P  (VLEN_P),
    .OFF_W_P (OFF_W_P),
    .LOG_W   (LOG_W)
  ) u_vlmax (
    .sew      (sew),
    .lmul     (lmul),
    .vl       (vl),
    .vlmax    (calc_vlmax),
    .eff_vl   (calc_evl),
    .epr_log2 (calc_l2)
  );

  // Lane 1 offset wraps at OFF_W bits; wen1 is computed on the unwrapped value.
  function automatic uop_t make_uop(input logic [OFF_W_P:0] i,
                                    input logic [OFF_W_P:0] evl,
                                    input logic [LOG_W-1:0] l2,
                                    input logic [4:0]       base);
    uop_t               u;
    logic [OFF_W_P:0]   i1;
    logic [OFF_W_P-1:0] mask;
    i1         = i + 1'b1;
    mask       = OFF_W_P'((32'd1 << l2) - 32'd1);
    u.valid    = 1'b1;
    u.woffset0 = i[OFF_W_P-1:0];
    u.woffset1 = i1[OFF_W_P-1:0];
    u.vd0      = base + 5'(u.woffset0 >> l2);
    u.vd1      = base + 5'(u.woffset1 >> l2);
    u.elem0    = 4'(u.woffset0 & mask);
    u.elem1    = 4'(u.woffset1 & mask);
    u.wen0     = 1'b1;
    u.wen1     = (i1 < evl);
    u.last     = ((i + (OFF_W_P+1)'(2)) >= evl);
    return u;
  endfunction

  always_comb begin
    // NOTE: every next-state value gets a default first so no latch is inferred.
    state_d = state_q;
    idx_d   = idx_q;
    evl_d   = evl_q;
    l2_d    = l2_q;
    vd_d    = vd_q;
    uop_d   = uop_q;
    done_d  = 1'b0;
    if (flush) begin
      state_d = IDLE;
      uop_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_valid) begin
            evl_d = calc_evl;
            l2_d  = calc_l2;
            vd_d  = vd;
            if (calc_vlmax == '0 || {1'b0, vstart} >= calc_evl) begin
              done_d = 1'b1;
            end else begin
              state_d = RUN;
              idx_d   = {1'b0, vstart};
              uop_d   = make_uop({1'b0, vstart}, calc_evl, calc_l2, vd);
            end
          end
        end
        RUN: begin
          if (!stall) begin
            if (uop_q.last) begin
              state_d = IDLE;
              uop_d   = '0;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + (OFF_W_P+1)'(2);
              uop_d = make_uop(idx_d, evl_q, l2_q, vd_q);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      evl_q   <= '0;
      l2_q    <= '0;
      vd_q    <= '0;
      uop_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      evl_q   <= evl_d;
      l2_q    <= l2_d;
      vd_q    <= vd_d;
      uop_q   <= uop_d;
      done_q  <= done_d;
    end
  end

  assign start_ready = (state_q == IDLE) && !RST;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign uop_valid   = uop_q.valid;
  assign woffset0    = uop_q.woffset0;
  assign woffset1    = uop_q.woffset1;
  assign vd0         = uop_q.vd0;
  assign vd1         = uop_q.vd1;
  assign elem0       = uop_q.elem0;
  assign elem1       = uop_q.elem1;
  assign wen0        = uop_q.wen0;
  assign wen1        = uop_q.wen1;
  assign uop_last    = uop_q.last;

endmodule

// File: tb/tb_rv32v_uop_sequencer.sv
// Self-checking bench: a queue-based model of the expected micro-op stream
// plus directed literal scenarios and randomized traffic.
module tb_rv32v_uop_sequencer;
  import rv32v_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [31:0] vl = '0;
  logic [6:0]  vstart = '0;
  sew_t        sew = SEW8;
  vlmul_t      lmul = LMUL_1;
  logic [4:0]  vd = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        uop_valid;
  logic [6:0]  woffset0, woffset1;
  logic [4:0]  vd0, vd1;
  logic [3:0]  elem0, elem1;
  logic        wen0, wen1, uop_last, done, busy;

  rv32v_uop_sequencer dut (
    .CLK(CLK), .RST(RST), .start_valid(start_valid), .start_ready(start_ready),
    .vl(vl), .vstart(vstart), .sew(sew), .lmul(lmul), .vd(vd),
    .stall(stall), .flush(flush), .uop_valid(uop_valid),
    .woffset0(woffset0), .woffset1(woffset1), .vd0(vd0), .vd1(vd1),
    .elem0(elem0), .elem1(elem1), .wen0(wen0), .wen1(wen1),
    .uop_last(uop_last), .done(done), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the whole instruction is expanded into a list of micro-ops on acceptance.
  typedef struct {
    int wo0, wo1, vd0, vd1, el0, el1;
    bit wen1, last;
  } muop_t;

  muop_t m_q[$];
  bit    m_busy = 0;
  bit    m_done = 0;
  bit    chk_en = 0;

  function automatic longint vlmax_of(input int s, input int l);
    longint epr = VLEN / (8 << s);
    case (l)
      0, 1, 2, 3: return epr * (1 << l);
      5:          return epr / 8;
      6:          return epr / 4;
      7:          return epr / 2;
      default:    return 0;
    endcase
  endfunction

  task automatic model_step();
    longint eff;
    longint epr;
    muop_t  u;
    m_done = 0;
    if (RST || flush) begin
      m_q.delete();
      m_busy = 0;
    end else if (!m_busy) begin
      if (start_valid) begin
        eff = vlmax_of(int'(sew), int'(lmul));
        if (vl < eff) eff = vl;
        if (vstart >= eff) begin
          m_done = 1;
        end else begin
          epr = VLEN / (8 << int'(sew));
          for (longint e = vstart; e < eff; e += 2) begin
            u.wo0  = int'(e % 128);
            u.wo1  = int'((e + 1) % 128);
            u.vd0  = int'((vd + u.wo0 / epr) % 32);
            u.vd1  = int'((vd + u.wo1 / epr) % 32);
            u.el0  = int'(u.wo0 % epr);
            u.el1  = int'(u.wo1 % epr);
            u.wen1 = (e + 1 < eff);
            u.last = (e + 2 >= eff);
            m_q.push_back(u);
          end
          m_busy = 1;
        end
      end
    end else if (!stall) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        m_busy = 0;
        m_done = 1;
      end
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("uop_valid", uop_valid, m_busy);
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("start_ready", start_ready, !m_busy && !RST);
      if (m_busy) begin
        check("woffset0", woffset0, m_q[0].wo0);
        check("woffset1", woffset1, m_q[0].wo1);
        check("vd0", vd0, m_q[0].vd0);
        check("vd1", vd1, m_q[0].vd1);
        check("elem0", elem0, m_q[0].el0);
        check("elem1", elem1, m_q[0].el1);
        check("wen0", wen0, 1);
        check("wen1", wen1, m_q[0].wen1);
        check("uop_last", uop_last, m_q[0].last);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic begin_insn(input sew_t s, input vlmul_t l, input logic [31:0] v,
                            input logic [6:0] vs, input logic [4:0] d);
    sew = s; lmul = l; vl = v; vstart = vs; vd = d;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
  endtask

  task automatic expect_uop(input string tag, input int o0, input int r0, input int e0,
                            input int o1, input int r1, input int e1,
                            input bit w1, input bit last);
    check({tag, ".valid"}, uop_valid, 1);
    check({tag, ".woffset0"}, woffset0, o0);
    check({tag, ".vd0"}, vd0, r0);
    check({tag, ".elem0"}, elem0, e0);
    check({tag, ".woffset1"}, woffset1, o1);
    check({tag, ".vd1"}, vd1, r1);
    check({tag, ".elem1"}, elem1, e1);
    check({tag, ".wen1"}, wen1, w1);
    check({tag, ".last"}, uop_last, last);
  endtask

  int lm_tab[7] = '{0, 1, 2, 3, 5, 6, 7};

  initial begin
    // Reset
    tick();
    chk_en = 1;
    tick();
    check("rst.start_ready", start_ready, 0);
    check("rst.uop_valid", uop_valid, 0);
    RST = 1'b0;
    #1;
    check("rst.ready_after", start_ready, 1);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.woffset0", woffset0, 0);
    check("rst.woffset1", woffset1, 0);
    check("rst.vd0", vd0, 0);
    check("rst.wen0", wen0, 0);
    check("rst.last", uop_last, 0);
    tick();

    // e32 m1, vl=4, vd=8
    begin_insn(SEW32, LMUL_1, 4, 0, 8);
    expect_uop("a0", 0, 8, 0, 1, 8, 1, 1, 0);
    tick();
    expect_uop("a1", 2, 8, 2, 3, 8, 3, 1, 1);
    tick();
    check("a.done", done, 1);
    check("a.valid_off", uop_valid, 0);
    check("a.ready", start_ready, 1);
    tick();
    check("a.done_once", done, 0);

    // e8 m2, vl=20, vstart=15, vd=4
    begin_insn(SEW8, LMUL_2, 20, 15, 4);
    expect_uop("b0", 15, 4, 15, 16, 5, 0, 1, 0);
    tick();
    expect_uop("b1", 17, 5, 1, 18, 5, 2, 1, 0);
    tick();
    expect_uop("b2", 19, 5, 3, 20, 5, 4, 0, 1);
    tick();
    check("b.done", done, 1);
    tick();

    // e32 mf2, vl=9 clips to 2; then vl=0
    begin_insn(SEW32, LMUL_F2, 9, 0, 2);
    expect_uop("c0", 0, 2, 0, 1, 2, 1, 1, 1);
    tick();
    check("c.done", done, 1);
    begin_insn(SEW8, LMUL_1, 0, 0, 0);
    check("c.vl0_valid", uop_valid, 0);
    check("c.vl0_done", done, 1);
    check("c.vl0_busy", busy, 0);
    tick();
    check("c.vl0_done_once", done, 0);

    // e16 m1, vl=8, stall 3 cycles on the 2nd micro-op
    begin_insn(SEW16, LMUL_1, 8, 0, 3);
    expect_uop("d0", 0, 3, 0, 1, 3, 1, 1, 0);
    tick();
    expect_uop("d1", 2, 3, 2, 3, 3, 3, 1, 0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_uop("d1_hold", 2, 3, 2, 3, 3, 3, 1, 0);
    end
    stall = 1'b0;
    tick();
    expect_uop("d2", 4, 3, 4, 5, 3, 5, 1, 0);
    tick();
    expect_uop("d3", 6, 3, 6, 7, 3, 7, 1, 1);
    tick();
    check("d.done", done, 1);
    tick();

    // flush on the 2nd of 4 micro-ops, then a clean restart
    begin_insn(SEW32, LMUL_2, 8, 0, 10);
    tick();
    expect_uop("e1", 2, 10, 2, 3, 10, 3, 1, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("e.valid", uop_valid, 0);
    check("e.done", done, 0);
    check("e.ready", start_ready, 1);
    check("e.busy", busy, 0);
    tick();
    check("e.no_late_done", done, 0);
    begin_insn(SEW32, LMUL_1, 4, 1, 6);
    expect_uop("e_r0", 1, 6, 1, 2, 6, 2, 1, 0);
    tick();
    expect_uop("e_r1", 3, 6, 3, 4, 7, 0, 0, 1);
    tick();
    check("e.restart_done", done, 1);
    tick();

    // RST mid-RUN
    begin_insn(SEW8, LMUL_8, 200, 0, 0);
    tick();
    tick();
    RST = 1'b1;
    tick();
    check("f.valid", uop_valid, 0);
    check("f.busy", busy, 0);
    check("f.woffset0", woffset0, 0);
    check("f.woffset1", woffset1, 0);
    check("f.vd1", vd1, 0);
    check("f.elem1", elem1, 0);
    check("f.wen1", wen1, 0);
    check("f.done", done, 0);
    RST = 1'b0;
    #1;
    check("f.ready", start_ready, 1);
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      start_valid = ($urandom_range(0, 1) == 1);
      sew  = sew_t'($urandom_range(0, 2));
      lmul = vlmul_t'(lm_tab[$urandom_range(0, 6)]);
      vd   = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 9))
        0:       vl = '0;
        1:       vl = $urandom;
        2:       vl = $urandom_range(100, 300);
        default: vl = $urandom_range(1, 40);
      endcase
      vstart = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(0, 127))
                                           : 7'($urandom_range(0, 12));
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 39) == 0);
      RST   = ($urandom_range(0, 399) == 0);
      tick();
    end
    start_valid = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    RST = 1'b0;
    for (int i = 0; i < 80; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
